pipe_sub_borrow_chain: RTL and testbench

//  Pipelined multi-slice subtractor: diff = a - b - borrow_in, built from SLICE_W-bit

---
 rtl/pipe_sub_borrow_chain_if.sv | 26 ++
 rtl/pipe_sub_borrow_chain.sv | 96 +++++++++
 tb/tb_pipe_sub_borrow_chain.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/pipe_sub_borrow_chain_if.sv
// Operand/result bundle for the pipelined borrow-chain subtractor.
// The master drives operands and out_ready; the slave returns the result and in_ready.
interface pipe_sub_borrow_chain_if #(
  parameter int W = 24
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         borrow_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         borrow_out;
  logic         overflow;

  modport master (
    output in_valid, a, b, borrow_in, out_ready,
    input  in_ready, out_valid, diff, borrow_out, overflow
  );

  modport slave (
    input  in_valid, a, b, borrow_in, out_ready,
    output in_ready, out_valid, diff, borrow_out, overflow
  );
endinterface

// File: rtl/pipe_sub_borrow_chain.sv
// diff = a - b - borrow_in, one SLICE_W-bit borrow-ripple slice per stage, SLICES-cycle latency;
// the whole pipe freezes while out_valid && !out_ready. `define SUB_SATURATE_EN clamps underflow to 0.
module pipe_sub_borrow_chain #(
  parameter int SLICE_W = 6,
  parameter int SLICES  = 4
) (
  input logic                   clk,
  input logic                   rst,
  pipe_sub_borrow_chain_if.slave bus
);
  localparam int W = SLICE_W * SLICES;

  logic [SLICES-1:0] vld_q, vld_d;
  logic [SLICES-1:0] bo_q, bo_d;
  logic [W-1:0]      a_q   [SLICES];
  logic [W-1:0]      a_d   [SLICES];
  logic [W-1:0]      b_q   [SLICES];
  logic [W-1:0]      b_d   [SLICES];
  logic [W-1:0]      dif_q [SLICES];
  logic [W-1:0]      dif_d [SLICES];
  logic [SLICE_W:0]  res;
  logic              stall;
  logic              advance;

  function automatic logic [SLICE_W:0] slice_sub(
    input logic [SLICE_W-1:0] x,
    input logic [SLICE_W-1:0] y,
    input logic               bi
  );
    logic [SLICE_W-1:0] d;
    logic               br;
    br = bi;
    d  = '0;
    for (int i = 0; i < SLICE_W; i++) begin
      d[i] = x[i] ^ y[i] ^ br;
      br   = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & br);
    end
    return {br, d};
  endfunction

  assign stall   = vld_q[SLICES-1] && !bus.out_ready;
  assign advance = !stall;

  // Each stage keeps full-width operands and partial result; only its own slice is computed.
  always_comb begin
    res         = slice_sub(bus.a[SLICE_W-1:0], bus.b[SLICE_W-1:0], bus.borrow_in);
    a_d[0]      = bus.a;
    b_d[0]      = bus.b;
    dif_d[0]    = '0;
    dif_d[0][SLICE_W-1:0] = res[SLICE_W-1:0];
    bo_d[0]     = res[SLICE_W];
    vld_d[0]    = bus.in_valid;
    for (int k = 1; k < SLICES; k++) begin
      res = slice_sub(a_q[k-1][k*SLICE_W +: SLICE_W], b_q[k-1][k*SLICE_W +: SLICE_W], bo_q[k-1]);
      a_d[k]   = a_q[k-1];
      b_d[k]   = b_q[k-1];
      dif_d[k] = dif_q[k-1];
      dif_d[k][k*SLICE_W +: SLICE_W] = res[SLICE_W-1:0];
      bo_d[k]  = res[SLICE_W];
      vld_d[k] = vld_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      bo_q  <= '0;
      for (int k = 0; k < SLICES; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        dif_q[k] <= '0;
      end
    end else if (advance) begin
      vld_q <= vld_d;
      bo_q  <= bo_d;
      for (int k = 0; k < SLICES; k++) begin
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
        dif_q[k] <= dif_d[k];
      end
    end
  end

  assign bus.in_ready   = !stall;
  assign bus.out_valid  = vld_q[SLICES-1];
  assign bus.borrow_out = bo_q[SLICES-1];
  // Overflow is judged on the raw difference, before any saturation.
  assign bus.overflow   = (a_q[SLICES-1][W-1] != b_q[SLICES-1][W-1]) &&
                          (dif_q[SLICES-1][W-1] != a_q[SLICES-1][W-1]);

`ifdef SUB_SATURATE_EN
  assign bus.diff = bo_q[SLICES-1] ? '0 : dif_q[SLICES-1];
`else
  assign bus.diff = dif_q[SLICES-1];
`endif
endmodule

// File: tb/tb_pipe_sub_borrow_chain.sv
// Directed and random bench for pipe_sub_borrow_chain against an arithmetic reference queue.
module tb_pipe_sub_borrow_chain;
  localparam int W      = 24;
  localparam int SLICES = 4;

  typedef struct {
    logic [W-1:0] diff;
    logic         bo;
    logic         ovf;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   n_out    = 0;
  bit   lat_chk  = 1'b0;

  pipe_sub_borrow_chain_if #(.W(W)) bus ();

  pipe_sub_borrow_chain #(.SLICE_W(6), .SLICES(SLICES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin, input int c);
    exp_t       e;
    logic [W:0] full;
    full  = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
    e.diff = full[W-1:0];
    e.bo   = full[W];
    e.ovf  = (a[W-1] != b[W-1]) && (full[W-1] != a[W-1]);
`ifdef SUB_SATURATE_EN
    if (e.bo) e.diff = '0;
`endif
    e.cyc = c;
    return e;
  endfunction

  // One cycle: drive at negedge, observe after settling, score both handshakes.
  task automatic tick(input logic iv, input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tbin, input logic ordy);
    exp_t e;
    @(negedge clk);
    cyc++;
    bus.in_valid  = iv;
    bus.a         = ta;
    bus.b         = tb_;
    bus.borrow_in = tbin;
    bus.out_ready = ordy;
    #1;
    if (bus.out_valid && ordy) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out", W'(bus.out_valid), W'(0));
      end else begin
        e = exp_q.pop_front();
        n_out++;
        chk("diff", bus.diff, e.diff);
        chk("borrow_out", W'(bus.borrow_out), W'(e.bo));
        chk("overflow", W'(bus.overflow), W'(e.ovf));
        if (lat_chk) chk("latency", W'(cyc - e.cyc), W'(SLICES));
      end
    end
    if (iv && bus.in_ready) exp_q.push_back(model(ta, tb_, tbin, cyc));
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) tick(1'b0, '0, '0, 1'b0, 1'b1);
    chk("drained", W'(exp_q.size()), W'(0));
  endtask

  task automatic rand_op(input logic ordy);
    logic [W-1:0] ra, rb;
    ra = W'($urandom);
    rb = ($urandom_range(0, 7) == 0) ? ra : W'($urandom);
    tick(1'b1, ra, rb, 1'($urandom_range(0, 1)), ordy);
  endtask

  initial begin
    int base;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.borrow_in = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", W'(bus.out_valid), W'(0));
    chk("rst_diff", bus.diff, W'(0));
    chk("rst_borrow_out", W'(bus.borrow_out), W'(0));
    chk("rst_overflow", W'(bus.overflow), W'(0));
    chk("rst_in_ready", W'(bus.in_ready), W'(1));

    // Directed single operations with exact latency
    lat_chk = 1'b1;
    tick(1'b1, 24'h000010, 24'h000001, 1'b0, 1'b1);
    drain(12);
    tick(1'b1, 24'h000000, 24'h000001, 1'b0, 1'b1);
    drain(12);
    tick(1'b1, 24'h800000, 24'h000001, 1'b0, 1'b1);
    tick(1'b1, 24'h00003F, 24'h00003F, 1'b1, 1'b1);
    tick(1'b1, 24'h7FFFFF, 24'hFFFFFF, 1'b0, 1'b1);
    drain(12);

    // Back-to-back random ops: fixed latency plus in-order implies consecutive results
    base = n_out;
    repeat (10) rand_op(1'b1);
    drain(20);
    chk("b2b_count", W'(n_out - base), W'(10));

    // Fill, stall for 5 cycles, release
    lat_chk = 1'b0;
    base = n_out;
    repeat (SLICES) rand_op(1'b1);
    for (int i = 0; i < 5; i++) begin
      rand_op(1'b0);
      chk("stall_in_ready", W'(bus.in_ready), W'(0));
      chk("stall_out_valid", W'(bus.out_valid), W'(1));
      chk("stall_diff_held", bus.diff, exp_q[0].diff);
    end
    drain(20);
    chk("stall_count", W'(n_out - base), W'(SLICES));

    // Random mix with sporadic backpressure
    repeat (40) begin
      if ($urandom_range(0, 3) == 0) tick(1'b0, '0, '0, 1'b0, 1'($urandom_range(0, 1)));
      else rand_op(1'($urandom_range(0, 3) != 0));
    end
    drain(40);

    // Reset with three ops in flight
    repeat (3) rand_op(1'b1);
    @(negedge clk);
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    #1;
    chk("midrst_out_valid", W'(bus.out_valid), W'(0));
    chk("midrst_diff", bus.diff, W'(0));
    chk("midrst_in_ready", W'(bus.in_ready), W'(1));
    base = n_out;
    repeat (10) tick(1'b0, '0, '0, 1'b0, 1'b1);
    chk("midrst_no_stale", W'(n_out - base), W'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
